// File: rtl/dlsc_axi_router_return_if.sv
// Return-path bus bundle for dlsc_axi_router_return: command push, per-sink
// response inputs and per-source response outputs. clk/rst_n stay outside.
interface dlsc_axi_router_return_if #(
    parameter int DATA     = 32,
    parameter int SOURCES  = 1,
    parameter int SOURCESB = 1,
    parameter int SINKS    = 1,
    parameter int SINKSB   = 1
);
    logic [SOURCES-1:0]      cmd_full_source;
    logic [SINKS-1:0]        cmd_full_sink;
    logic                    cmd_push;
    logic [SOURCES-1:0]      cmd_source_onehot;
    logic [SINKS-1:0]        cmd_sink_onehot;
    logic [SOURCESB-1:0]     cmd_source;
    logic [SINKSB-1:0]       cmd_sink;
    logic [SINKS-1:0]        sink_ready;
    logic [SINKS-1:0]        sink_valid;
    logic [SINKS-1:0]        sink_last;
    logic [SINKS*DATA-1:0]   sink_data;
    logic [SOURCES-1:0]      source_ready;
    logic [SOURCES-1:0]      source_valid;
    logic [SOURCES-1:0]      source_last;
    logic [SOURCES*DATA-1:0] source_data;

    // Router side
    modport slave (
        output cmd_full_source, cmd_full_sink, sink_ready,
               source_valid, source_last, source_data,
        input  cmd_push, cmd_source_onehot, cmd_sink_onehot, cmd_source, cmd_sink,
               sink_valid, sink_last, sink_data, source_ready
    );

    // Environment side (command issuer, sinks and sources)
    modport master (
        input  cmd_full_source, cmd_full_sink, sink_ready,
               source_valid, source_last, source_data,
        output cmd_push, cmd_source_onehot, cmd_sink_onehot, cmd_source, cmd_sink,
               sink_valid, sink_last, sink_data, source_ready
    );
endinterface

// File: rtl/dlsc_axi_router_return.sv
// Return-path router: each command records its route in a per-source queue
// (sink index) and a per-sink queue (source index). A response burst flows
// only while both queue heads point at each other, which keeps per-source and
// per-sink ordering without any arbitration. Queues pop on the last beat.
module dlsc_axi_router_return #(
    parameter int DATA     = 32,
    parameter int MOT      = 16,
    parameter int SOURCES  = 1,
    parameter int SOURCESB = 1,
    parameter int SINKS    = 1,
    parameter int SINKSB   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dlsc_axi_router_return_if.slave   bus
);

    localparam int CNTB = $clog2(MOT + 1);
    localparam int PTRB = (MOT > 1) ? $clog2(MOT) : 1;

    // Circular pointer advance, wrapping from MOT-1 back to 0
    function automatic logic [PTRB-1:0] ptr_inc(input logic [PTRB-1:0] p);
        if (p == PTRB'(MOT - 1)) begin
            return {PTRB{1'b0}};
        end else begin
            return p + PTRB'(1);
        end
    endfunction

    // Occupancy update; a simultaneous push and pop leaves the count unchanged
    function automatic logic [CNTB-1:0] cnt_next(input logic [CNTB-1:0] cnt,
                                                 input logic push, input logic pop);
        case ({push, pop})
            2'b10:   return cnt + CNTB'(1);
            2'b01:   return cnt - CNTB'(1);
            default: return cnt;
        endcase
    endfunction

    // Per-source queues hold sink indices
    logic [SINKSB-1:0]   src_mem_r [SOURCES][MOT];
    logic [PTRB-1:0]     src_rd_r  [SOURCES];
    logic [PTRB-1:0]     src_wr_r  [SOURCES];
    logic [CNTB-1:0]     src_cnt_r [SOURCES];
    logic [SOURCES-1:0]  src_full_r;
    logic [SOURCES-1:0]  src_push_s;
    logic [SOURCES-1:0]  src_pop_s;

    // Per-sink queues hold source indices
    logic [SOURCESB-1:0] snk_mem_r [SINKS][MOT];
    logic [PTRB-1:0]     snk_rd_r  [SINKS];
    logic [PTRB-1:0]     snk_wr_r  [SINKS];
    logic [CNTB-1:0]     snk_cnt_r [SINKS];
    logic [SINKS-1:0]    snk_full_r;
    logic [SINKS-1:0]    snk_push_s;
    logic [SINKS-1:0]    snk_pop_s;

    logic [SINKS-1:0]        route_s [SOURCES];
    logic [SOURCES-1:0]      source_valid_s;
    logic [SOURCES-1:0]      source_last_s;
    logic [SOURCES*DATA-1:0] source_data_s;
    logic [SINKS-1:0]        sink_ready_s;

    // A push into a full queue is dropped for that queue only
    assign src_push_s = {SOURCES{bus.cmd_push}} & bus.cmd_source_onehot & ~src_full_r;
    assign snk_push_s = {SINKS{bus.cmd_push}}   & bus.cmd_sink_onehot   & ~snk_full_r;

    // Route match: both queue heads valid and pointing at each other
    always_comb begin
        for (int j = 0; j < SOURCES; j++) begin
            for (int k = 0; k < SINKS; k++) begin
                route_s[j][k] = (src_cnt_r[j] != {CNTB{1'b0}}) &&
                                (src_mem_r[j][src_rd_r[j]] == SINKSB'(k)) &&
                                (snk_cnt_r[k] != {CNTB{1'b0}}) &&
                                (snk_mem_r[k][snk_rd_r[k]] == SOURCESB'(j));
            end
        end
    end

    // Forwarding muxes, back-pressure and last-beat pops along matched routes
    always_comb begin
        source_valid_s = {SOURCES{1'b0}};
        source_last_s  = {SOURCES{1'b0}};
        source_data_s  = {(SOURCES*DATA){1'b0}};
        sink_ready_s   = {SINKS{1'b0}};
        src_pop_s      = {SOURCES{1'b0}};
        snk_pop_s      = {SINKS{1'b0}};
        for (int j = 0; j < SOURCES; j++) begin
            for (int k = 0; k < SINKS; k++) begin
                source_valid_s[j] = source_valid_s[j] | (route_s[j][k] & bus.sink_valid[k]);
                source_last_s[j]  = source_last_s[j]  | (route_s[j][k] & bus.sink_last[k]);
                source_data_s[j*DATA +: DATA] = source_data_s[j*DATA +: DATA] |
                    ({DATA{route_s[j][k]}} & bus.sink_data[k*DATA +: DATA]);
                sink_ready_s[k]   = sink_ready_s[k] | (route_s[j][k] & bus.source_ready[j]);
                src_pop_s[j] = src_pop_s[j] | (route_s[j][k] & bus.sink_valid[k] &
                                               bus.source_ready[j] & bus.sink_last[k]);
                snk_pop_s[k] = snk_pop_s[k] | (route_s[j][k] & bus.sink_valid[k] &
                                               bus.source_ready[j] & bus.sink_last[k]);
            end
        end
    end

    assign bus.source_valid    = source_valid_s;
    assign bus.source_last     = source_last_s;
    assign bus.source_data     = source_data_s;
    assign bus.sink_ready      = sink_ready_s;
    assign bus.cmd_full_source = src_full_r;
    assign bus.cmd_full_sink   = snk_full_r;

    // Source queue pointers, occupancy and registered full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SOURCES; j++) begin
                src_rd_r[j]  <= {PTRB{1'b0}};
                src_wr_r[j]  <= {PTRB{1'b0}};
                src_cnt_r[j] <= {CNTB{1'b0}};
            end
            src_full_r <= {SOURCES{1'b0}};
        end else begin
            for (int j = 0; j < SOURCES; j++) begin
                src_rd_r[j]   <= src_pop_s[j]  ? ptr_inc(src_rd_r[j]) : src_rd_r[j];
                src_wr_r[j]   <= src_push_s[j] ? ptr_inc(src_wr_r[j]) : src_wr_r[j];
                src_cnt_r[j]  <= cnt_next(src_cnt_r[j], src_push_s[j], src_pop_s[j]);
                src_full_r[j] <= (cnt_next(src_cnt_r[j], src_push_s[j], src_pop_s[j]) == CNTB'(MOT));
            end
        end
    end

    // Sink queue pointers, occupancy and registered full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SINKS; k++) begin
                snk_rd_r[k]  <= {PTRB{1'b0}};
                snk_wr_r[k]  <= {PTRB{1'b0}};
                snk_cnt_r[k] <= {CNTB{1'b0}};
            end
            snk_full_r <= {SINKS{1'b0}};
        end else begin
            for (int k = 0; k < SINKS; k++) begin
                snk_rd_r[k]   <= snk_pop_s[k]  ? ptr_inc(snk_rd_r[k]) : snk_rd_r[k];
                snk_wr_r[k]   <= snk_push_s[k] ? ptr_inc(snk_wr_r[k]) : snk_wr_r[k];
                snk_cnt_r[k]  <= cnt_next(snk_cnt_r[k], snk_push_s[k], snk_pop_s[k]);
                snk_full_r[k] <= (cnt_next(snk_cnt_r[k], snk_push_s[k], snk_pop_s[k]) == CNTB'(MOT));
            end
        end
    end

    // Queue storage; contents are only observed through non-empty heads, so no reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < SOURCES; j++) begin
            if (src_push_s[j]) begin
                src_mem_r[j][src_wr_r[j]] <= bus.cmd_sink;
            end
        end
        for (int k = 0; k < SINKS; k++) begin
            if (snk_push_s[k]) begin
                snk_mem_r[k][snk_wr_r[k]] <= bus.cmd_source;
            end
        end
    end

endmodule
